// File: rtl/job_arbiter.sv
// Round-robin arbiter sharing one go/kill/done job engine among NUM_REQ requesters,
// with a BUSY watchdog and per-requester cancel that abort the job through eng_kill.
//
// state  | meaning
// IDLE   | waiting for any req; picks the next requester round-robin
// LAUNCH | one-cycle eng_go to the engine
// BUSY   | job running; watchdog counting, waiting for eng_done
// KILL   | eng_kill held for KILL_HOLD cycles after timeout or cancel
// GAP    | recovery cycle; advances the round-robin pointer
module job_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TIMER_W   = 8,
  parameter int TIMEOUT   = 32,
  parameter int KILL_HOLD = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] cancel,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               eng_go,
  output logic               eng_kill,
  input  logic               eng_done
);

  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, KILL, GAP} state_t;

  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] KILL_LAST = TIMER_W'(KILL_HOLD - 1);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt, grant_nxt, winner, cand;
  logic               found;
  logic [TIMER_W-1:0] timer, timer_nxt, timer_inc;
  logic [NUM_REQ-1:0] ack_nxt, err_nxt;

  // first requesting index at or above rr_ptr, wrapping; indices >= NUM_REQ never visited
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_id;
    rr_ptr_nxt = rr_ptr;
    timer_nxt  = timer;
    ack_nxt    = '0;
    err_nxt    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = winner;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_nxt = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        timer_nxt = timer_inc;
        // completion outranks a watchdog expiry or cancel in the same cycle
        if (eng_done) begin
          ack_nxt[grant_id] = 1'b1;
          state_nxt         = GAP;
        end else if (timer == TMO_LAST || cancel[grant_id]) begin
          timer_nxt = '0;
          state_nxt = KILL;
        end
      end
      KILL: begin
        timer_nxt = timer_inc;
        if (timer == KILL_LAST) begin
          err_nxt[grant_id] = 1'b1;
          state_nxt         = GAP;
        end
      end
      GAP: begin
        rr_ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      timer    <= '0;
      ack      <= '0;
      err      <= '0;
      eng_go   <= 1'b0;
      eng_kill <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      timer    <= timer_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      eng_go   <= (state_nxt == LAUNCH);
      eng_kill <= (state_nxt == KILL);
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_job_arbiter.sv
// Bench for job_arbiter: vector table, hand-written reset/fairness sequences, and
// random jobs checked against a job-level model of arbitration and outcome timing.
module tb_job_arbiter;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int TMO   = 32;
  localparam int KH    = 3;
  localparam int NEVER = 1000;
  localparam int NONE  = 9999;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, cancel, ack, err;
  logic [IDW-1:0] grant_id;
  logic           busy, eng_go, eng_kill;
  logic           eng_done_mdl, spur_done;
  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             eng_delay = NEVER;

  job_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMER_W(8), .TIMEOUT(TMO), .KILL_HOLD(KH)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .cancel(cancel), .ack(ack), .err(err),
    .grant_id(grant_id), .busy(busy), .eng_go(eng_go), .eng_kill(eng_kill),
    .eng_done(eng_done_mdl | spur_done));

  always #5 clk = ~clk;

  // engine: done pulses eng_delay cycles after the go cycle; kill or reset aborts it
  initial begin : engine
    int cnt;
    cnt = 0;
    eng_done_mdl = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      eng_done_mdl = 1'b0;
      if (!reset_n) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) eng_done_mdl = 1'b1;
        end
        if (eng_kill === 1'b1) cnt = 0;
        if (eng_go === 1'b1) cnt = eng_delay;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: still running at %0t, expected completion", $time);
    $fatal(1, "bench did not terminate");
  end

  typedef struct {
    int           wait_n;
    int           go_cyc;
    int           grant;
    logic [N-1:0] ack_v;
    logic [N-1:0] err_v;
    int           out_o;
    int           kill_first;
    int           kill_cnt;
    int           bad;
  } res_t;

  typedef struct {
    logic [N-1:0] req_v;
    int           delay;
    logic [N-1:0] ca_v;
    int           ca_o;
    logic [N-1:0] cb_v;
    int           cb_o;
    int           drop_o;
    int           exp_grant;
    bit           exp_ack;
    int           exp_out;
    int           exp_kf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // highest priority = smallest forward distance from the pointer
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (r[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  // offsets relative to the go cycle: done at d, cancel seen at c, watchdog at TMO
  function automatic void predict(input int d, input int c, output bit is_ack,
                                  output int out_o, output int kf);
    int x;
    if (d <= c && d <= TMO) begin
      is_ack = 1'b1;
      out_o  = d + 1;
      kf     = 0;
    end else begin
      x      = (c < TMO) ? c : TMO;
      is_ack = 1'b0;
      kf     = x + 1;
      out_o  = x + 1 + KH;
    end
  endfunction

  task automatic run_job(input logic [N-1:0] ca_v, input int ca_o, input logic [N-1:0] cb_v,
                         input int cb_o, input int drop_o, output res_t r);
    logic [IDW-1:0] g;
    r.wait_n = 0; r.go_cyc = -1; r.grant = -1; r.ack_v = '0; r.err_v = '0;
    r.out_o = -1; r.kill_first = 0; r.kill_cnt = 0; r.bad = 0;
    while (eng_go !== 1'b1 && r.wait_n < 60) begin
      tick();
      r.wait_n++;
    end
    if (eng_go !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL go_wait: no eng_go after %0d cycles, expected one", r.wait_n);
      return;
    end
    g = grant_id;
    r.grant  = int'(g);
    r.go_cyc = cyc;
    if (busy !== 1'b1) r.bad |= 1;
    for (int o = 1; o <= 80; o++) begin
      tick();
      cancel = ((o == ca_o) ? ca_v : '0) | ((o == cb_o) ? cb_v : '0);
      if (o == drop_o) req[g] = 1'b0;
      if (eng_go !== 1'b0) r.bad |= 2;
      if ((ack & err) != '0 || $countones(ack | err) > 1) r.bad |= 4;
      if (grant_id !== g) r.bad |= 8;
      if (busy !== 1'b1) r.bad |= 16;
      if (eng_kill === 1'b1) begin
        if (r.kill_first == 0) r.kill_first = o;
        r.kill_cnt++;
      end
      if ((ack | err) != '0) begin
        r.ack_v = ack;
        r.err_v = err;
        r.out_o = o;
        break;
      end
    end
    cancel = '0;
  endtask

  task automatic check_job(input string tag, input res_t r, input int exp_grant, input bit exp_ack,
                           input int exp_out, input int exp_kf, input int exp_wait);
    logic [N-1:0] one;
    one = N'(1) << exp_grant;
    chk({tag, " grant"}, 32'(r.grant), 32'(exp_grant));
    chk({tag, " ack"}, 32'(r.ack_v), exp_ack ? 32'(one) : 32'd0);
    chk({tag, " err"}, 32'(r.err_v), exp_ack ? 32'd0 : 32'(one));
    chk({tag, " out_latency"}, 32'(r.out_o), 32'(exp_out));
    chk({tag, " kill_start"}, 32'(r.kill_first), 32'(exp_kf));
    chk({tag, " kill_len"}, 32'(r.kill_cnt), (exp_kf == 0) ? 32'd0 : 32'(KH));
    chk({tag, " protocol"}, 32'(r.bad), 32'd0);
    if (exp_wait > 0) chk({tag, " go_spacing"}, 32'(r.wait_n), 32'(exp_wait));
  endtask

  initial begin
    vec_t         tbl[10];
    res_t         r;
    int           m_rr, prev_go, events;
    logic [N-1:0] rv, cv;
    int           d, ck, co, c_eff, dr, eg, eo, ekf;
    bit           ea;

    tbl[0] = '{4'b0010, 23,    4'b0000, NONE, 4'b0000, NONE, 0, 1, 1'b1, 24, 0};
    tbl[1] = '{4'b0100, NEVER, 4'b0000, NONE, 4'b0000, NONE, 0, 2, 1'b0, 36, 33};
    tbl[2] = '{4'b0100, NEVER, 4'b0001, 3,    4'b0100, 6,    0, 2, 1'b0, 10, 7};
    tbl[3] = '{4'b0100, 32,    4'b0000, NONE, 4'b0000, NONE, 0, 2, 1'b1, 33, 0};
    tbl[4] = '{4'b1001, 5,     4'b0000, NONE, 4'b0000, NONE, 0, 3, 1'b1, 6,  0};
    tbl[5] = '{4'b1001, 1,     4'b0000, NONE, 4'b0000, NONE, 0, 0, 1'b1, 2,  0};
    tbl[6] = '{4'b1001, 10,    4'b0001, 4,    4'b0000, NONE, 0, 3, 1'b1, 11, 0};
    tbl[7] = '{4'b0110, 40,    4'b0010, 1,    4'b0000, NONE, 0, 1, 1'b0, 5,  2};
    tbl[8] = '{4'b0110, 33,    4'b0000, NONE, 4'b0000, NONE, 0, 2, 1'b0, 36, 33};
    tbl[9] = '{4'b0110, 3,     4'b0000, NONE, 4'b0000, NONE, 1, 1, 1'b1, 4,  0};

    reset_n = 1'b0; req = '0; cancel = '0; spur_done = 1'b0;
    tick();
    tick();
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset grant_id", 32'(grant_id), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset eng_go", 32'(eng_go), 32'd0);
    chk("reset eng_kill", 32'(eng_kill), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      req       = tbl[i].req_v;
      eng_delay = tbl[i].delay;
      run_job(tbl[i].ca_v, tbl[i].ca_o, tbl[i].cb_v, tbl[i].cb_o, tbl[i].drop_o, r);
      check_job($sformatf("vec%0d", i), r, tbl[i].exp_grant, tbl[i].exp_ack,
                tbl[i].exp_out, tbl[i].exp_kf, (i == 0) ? 0 : 2);
    end

    req = '0;
    tick();
    chk("idle busy +1", 32'(busy), 32'd0);
    tick();
    chk("idle busy +2", 32'(busy), 32'd0);
    chk("idle ack_err +2", 32'(ack | err), 32'd0);

    // reset in the middle of a job: outputs clear at once and the job vanishes
    req       = 4'b0100;
    eng_delay = NEVER;
    for (int i = 0; i < 60 && eng_go !== 1'b1; i++) tick();
    chk("rst_job go", 32'(eng_go), 32'd1);
    chk("rst_job grant", 32'(grant_id), 32'd2);
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_job busy", 32'(busy), 32'd0);
    chk("rst_job grant_id", 32'(grant_id), 32'd0);
    chk("rst_job outputs", 32'({ack, err, eng_go, eng_kill}), 32'd0);
    req = '0;
    tick();
    tick();
    reset_n = 1'b1;
    events = 0;
    for (int i = 0; i < 40; i++) begin
      spur_done = (i == 10);
      tick();
      if ((ack | err) != '0 || eng_go !== 1'b0 || eng_kill !== 1'b0 || busy !== 1'b0) events++;
    end
    spur_done = 1'b0;
    chk("post_reset quiet", 32'(events), 32'd0);

    // all requesting: fresh pointer serves 0,1,2,3,0
    req       = 4'b1111;
    eng_delay = 4;
    prev_go   = -1;
    for (int k = 0; k < 5; k++) begin
      run_job('0, NONE, '0, NONE, 0, r);
      check_job($sformatf("rr%0d", k), r, k % N, 1'b1, 5, 0, (k == 0) ? 0 : 2);
      if (k > 0) chk($sformatf("rr%0d go_gap>=3", k), 32'(r.go_cyc - prev_go >= 3), 32'd1);
      prev_go = r.go_cyc;
    end

    m_rr = 1;
    for (int j = 0; j < 40; j++) begin
      rv    = N'($urandom_range(1, (1 << N) - 1));
      d     = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 45));
      ck    = int'($urandom_range(0, 2));
      co    = int'($urandom_range(1, 40));
      eg    = pick(rv, m_rr);
      cv    = '0;
      c_eff = NONE;
      if (ck == 1) begin
        cv[eg] = 1'b1;
        c_eff  = co;
      end else if (ck == 2) begin
        cv[(eg + int'($urandom_range(1, N - 1))) % N] = 1'b1;
      end
      dr = int'($urandom_range(0, 1));
      predict(d, c_eff, ea, eo, ekf);
      req       = rv;
      eng_delay = d;
      run_job(cv, co, '0, NONE, dr, r);
      check_job($sformatf("rnd%0d", j), r, eg, ea, eo, ekf, 2);
      m_rr = (eg + 1) % N;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
